// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the hardwired fetch/decode/execute controller.
// The control word mirrors every control input of the ALU system datapath.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_FETCH_L = 3'd1,
      S_FETCH_H = 3'd2,
      S_EXEC    = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   localparam int OP_BRA = 'h00;
   localparam int OP_BNE = 'h01;
   localparam int OP_INC = 'h02;
   localparam int OP_DEC = 'h03;
   localparam int OP_IMM = 'h04;
   localparam int OP_LD  = 'h05;
   localparam int OP_ST  = 'h06;
   localparam int OP_HLT = 'h07;

   localparam logic [2:0] FUN_DEC  = 3'b000;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_CLR  = 3'b011;
   localparam logic [4:0] ALU_PASS_A = 5'b10000;

   localparam logic [1:0] SEL_PC = 2'b00;
   localparam logic [1:0] SEL_SP = 2'b01;
   localparam logic [1:0] SEL_AR = 2'b10;

   localparam logic [1:0] MUXA_MEM = 2'b10;
   localparam logic [1:0] MUXA_IMM = 2'b11;
   localparam logic [1:0] MUXB_IMM = 2'b11;
   localparam logic       MUXC_ALU_LO = 1'b0;

   localparam logic [2:0] ARF_EN_PC  = 3'b100;
   localparam logic [2:0] ARF_EN_ALL = 3'b111;

   typedef struct packed {
      logic [2:0] rf_outa_sel;
      logic [2:0] rf_outb_sel;
      logic [2:0] rf_fun_sel;
      logic [3:0] rf_reg_sel;
      logic [3:0] rf_scr_sel;
      logic [4:0] alu_fun_sel;
      logic       alu_wf;
      logic [1:0] arf_outc_sel;
      logic [1:0] arf_outd_sel;
      logic [2:0] arf_fun_sel;
      logic [2:0] arf_reg_sel;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic       mux_c_sel;
   } ctrl_word_t;

   // Mem_CS is active-low, so the idle word keeps memory deselected.
   localparam ctrl_word_t CTRL_IDLE = '{mem_cs: 1'b1, default: '0};

   function automatic logic [3:0] onehot_rsel(input logic [1:0] rsel);
      return 4'b1000 >> rsel;
   endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational EXEC-cycle decode: IR + flags to control word, plus the
// illegal-opcode and halt indications used by the sequencer.
module instruction_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 6
) (
   input  logic [15:0] ir,
   input  logic [3:0]  flags,
   output ctrl_word_t  ctrl,
   output logic        illegal,
   output logic        is_halt
);

   logic [OPC_W-1:0] opcode;
   logic [1:0]       rsel;
   logic             unused_bits;

   assign opcode = ir[15 -: OPC_W];
   assign rsel   = ir[9:8];
   // Immediate/address bits reach the datapath directly; only Z matters here.
   assign unused_bits = ^{ir[7:0], flags[2:0]};

   always_comb begin
      ctrl    = CTRL_IDLE;
      illegal = 1'b0;
      is_halt = 1'b0;
      case (opcode)
         OPC_W'(OP_BRA), OPC_W'(OP_BNE): begin
            if (opcode == OPC_W'(OP_BRA) || !flags[3]) begin
               ctrl.mux_b_sel   = MUXB_IMM;
               ctrl.arf_fun_sel = FUN_LOAD;
               ctrl.arf_reg_sel = ARF_EN_PC;
            end
         end
         OPC_W'(OP_INC): begin
            ctrl.rf_fun_sel = FUN_INC;
            ctrl.rf_reg_sel = onehot_rsel(rsel);
         end
         OPC_W'(OP_DEC): begin
            ctrl.rf_fun_sel = FUN_DEC;
            ctrl.rf_reg_sel = onehot_rsel(rsel);
         end
         OPC_W'(OP_IMM): begin
            ctrl.mux_a_sel  = MUXA_IMM;
            ctrl.rf_fun_sel = FUN_LOAD;
            ctrl.rf_reg_sel = onehot_rsel(rsel);
         end
         OPC_W'(OP_LD): begin
            ctrl.arf_outd_sel = SEL_AR;
            ctrl.mem_cs       = 1'b0;
            ctrl.mux_a_sel    = MUXA_MEM;
            ctrl.rf_fun_sel   = FUN_LOAD;
            ctrl.rf_reg_sel   = onehot_rsel(rsel);
         end
         OPC_W'(OP_ST): begin
            ctrl.rf_outa_sel  = {1'b0, rsel};
            ctrl.alu_fun_sel  = ALU_PASS_A;
            ctrl.mux_c_sel    = MUXC_ALU_LO;
            ctrl.arf_outd_sel = SEL_AR;
            ctrl.mem_cs       = 1'b0;
            ctrl.mem_wr       = 1'b1;
         end
         OPC_W'(OP_HLT): is_halt = 1'b1;
         default:        illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute FSM driving the ALU system datapath: two-byte fetch into
// the IR, then a single execute cycle decoded by instruction_decoder.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  FlagsOut,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [2:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted,
   output logic        Illegal
);

   state_t     state, next_state;
   ctrl_word_t dec_ctrl, cw;
   logic       dec_illegal, dec_halt;

   instruction_decoder #(.OPC_W(OPC_W)) u_dec (
      .ir      (IROut),
      .flags   (FlagsOut),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .is_halt (dec_halt)
   );

   always_ff @(posedge Clock) begin
      if (Reset) state <= S_INIT;
      else       state <= next_state;
   end

   always_comb begin
      next_state = S_INIT;
      case (state)
         S_INIT:    next_state = S_FETCH_L;
         S_FETCH_L: next_state = S_FETCH_H;
         S_FETCH_H: next_state = S_EXEC;
         S_EXEC:    next_state = dec_halt ? S_HALT : S_FETCH_L;
         S_HALT:    next_state = S_HALT;
         default:   next_state = S_INIT;
      endcase
   end

   // Reset overrides the state decode so the INIT word is visible immediately.
   always_comb begin
      cw      = CTRL_IDLE;
      Halted  = 1'b0;
      Illegal = 1'b0;
      if (Reset || state == S_INIT) begin
         cw.arf_fun_sel = FUN_CLR;
         cw.arf_reg_sel = ARF_EN_ALL;
      end else begin
         case (state)
            S_FETCH_L, S_FETCH_H: begin
               cw.arf_outd_sel = SEL_PC;
               cw.mem_cs       = 1'b0;
               cw.ir_write     = 1'b1;
               cw.ir_lh        = (state == S_FETCH_H);
               cw.arf_fun_sel  = FUN_INC;
               cw.arf_reg_sel  = ARF_EN_PC;
            end
            S_EXEC: begin
               cw      = dec_ctrl;
               Illegal = dec_illegal;
            end
            S_HALT:  Halted = 1'b1;
            default: cw = CTRL_IDLE;
         endcase
      end
   end

   assign RF_OutASel  = cw.rf_outa_sel;
   assign RF_OutBSel  = cw.rf_outb_sel;
   assign RF_FunSel   = cw.rf_fun_sel;
   assign RF_RegSel   = cw.rf_reg_sel;
   assign RF_ScrSel   = cw.rf_scr_sel;
   assign ALU_FunSel  = cw.alu_fun_sel;
   assign ALU_WF      = cw.alu_wf;
   assign ARF_OutCSel = cw.arf_outc_sel;
   assign ARF_OutDSel = cw.arf_outd_sel;
   assign ARF_FunSel  = cw.arf_fun_sel;
   assign ARF_RegSel  = cw.arf_reg_sel;
   assign IR_LH       = cw.ir_lh;
   assign IR_Write    = cw.ir_write;
   assign Mem_WR      = cw.mem_wr;
   assign Mem_CS      = cw.mem_cs;
   assign MuxASel     = cw.mux_a_sel;
   assign MuxBSel     = cw.mux_b_sel;
   assign MuxCSel     = cw.mux_c_sel;

endmodule
